// File: rtl/fifo_stream_drain.sv
// Drains a 1-cycle-latency synchronous FIFO onto a valid/ready stream through a 2-entry buffer; first word 2 cycles after non-empty.
// Sustains 1 word/cycle; under back-pressure it stops reading once buffered + in-flight words reach 2, so nothing is dropped.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            level,
    output logic [CNT_WIDTH-1:0]  words_out
);

    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;

    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            cnt_after_pop;

    always_comb begin
        pop       = (count_q != 2'd0) & m_ready;
        // occupancy the next edge will see if no new read is issued; m_ready feeds this on purpose
        occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
        fifo_r_en = !fifo_empty && (occ < 2'd2);

        cnt_after_pop = count_q - {1'b0, pop};
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        words_d       = words_q;
        count_d       = cnt_after_pop;
        inflight_d    = fifo_r_en;

        if (pop) begin
            buf0_d  = buf1_q;
            words_d = words_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end

        // the returning word lands in the first free slot after this cycle's pop
        if (inflight_q) begin
            if (cnt_after_pop == 2'd0) begin
                buf0_d = fifo_data;
            end else begin
                buf1_d = fifo_data;
            end
            count_d = cnt_after_pop + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            words_q    <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            words_q    <= words_d;
        end
    end

    assign m_valid   = (count_q != 2'd0);
    assign m_data    = buf0_q;
    assign level     = count_q;
    assign words_out = words_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural 1-cycle-latency FIFO feeding the DUT, scoreboard of pushed words checked by a monitor.
module tb_fifo_stream_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] level;
    logic [15:0] words_out;

    logic       fifo_r_en4;
    logic       m_valid4;
    logic [7:0] m_data4;
    logic [1:0] level4;
    logic [3:0] words_out4;

    logic       tb_inflight;
    logic [7:0] fq[$];
    logic [7:0] inq[$];
    logic [7:0] expq[$];

    int n_vec = 0;
    int n_err = 0;
    int words_model = 0;
    bit hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    fifo_stream_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .level(level), .words_out(words_out)
    );

    fifo_stream_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
        .level(level4), .words_out(words_out4)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        inq.push_back(d);
        expq.push_back(d);
    endtask

    // FIFO model: registered read data, writes become visible one edge after they are issued
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            inq.delete();
            fifo_empty  <= 1'b1;
            fifo_data   <= 8'h00;
            tb_inflight <= 1'b0;
        end else begin
            tb_inflight <= fifo_r_en;
            if (fifo_r_en) begin
                if (fq.size() == 0) begin
                    chk(1'b0, "read_while_empty", 32'(fifo_r_en), 32'd0);
                end else begin
                    fifo_data <= fq.pop_front();
                end
            end
            while (inq.size() != 0) fq.push_back(inq.pop_front());
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            words_model = 0;
            hold_prev   = 1'b0;
        end else begin
            chk(words_out == 16'(words_model), "words_out", 32'(words_out), 32'(words_model));
            chk(words_out4 == 4'(words_model), "words_out_wrap", 32'(words_out4), 32'(words_model % 16));
            chk({fifo_r_en4, m_valid4, m_data4, level4} == {fifo_r_en, m_valid, m_data, level},
                "dut4_match", 32'({fifo_r_en4, m_valid4, m_data4, level4}), 32'({fifo_r_en, m_valid, m_data, level}));
            chk((32'(level) + 32'(tb_inflight)) <= 32'd2, "occupancy", 32'(level) + 32'(tb_inflight), 32'd2);
            if (fifo_empty) chk(!fifo_r_en, "r_en_while_empty", 32'(fifo_r_en), 32'd0);
            if (hold_prev) chk(m_valid && m_data == prev_data, "hold_stable", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    chk(1'b0, "extra_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    chk(m_data == e, "m_data", 32'(m_data), 32'(e));
                end
                words_model++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    initial begin
        int rd_cnt;
        int budget;
        rst     = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk(m_valid == 1'b0, "rst_m_valid", 32'(m_valid), 32'd0);
        chk(level == 2'd0, "rst_level", 32'(level), 32'd0);
        chk(words_out == 16'd0, "rst_words", 32'(words_out), 32'd0);
        chk(fifo_r_en == 1'b0, "rst_r_en", 32'(fifo_r_en), 32'd0);
        chk(m_data == 8'h00, "rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // streaming 0x01..0x08 with m_ready held high
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        @(posedge clk); #1;
        @(negedge clk);
        chk(fifo_r_en == 1'b1, "stream_first_r_en", 32'(fifo_r_en), 32'd1);
        chk(m_valid == 1'b0, "stream_lat0", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk(m_valid == 1'b0, "stream_lat1", 32'(m_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(m_valid == 1'b1, "stream_no_gap", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        chk(m_valid == 1'b0, "stream_end_valid", 32'(m_valid), 32'd0);
        chk(words_out == 16'd8, "stream_words", 32'(words_out), 32'd8);

        // back-pressure: only two reads may be issued while stalled
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        rd_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_r_en) rd_cnt++;
        end
        chk(rd_cnt == 2, "bp_reads", 32'(rd_cnt), 32'd2);
        chk(level == 2'd2, "bp_level", 32'(level), 32'd2);
        chk(m_data == 8'hA0, "bp_head", 32'(m_data), 32'hA0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(m_valid == 1'b1, "bp_release_no_gap", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        chk(m_valid == 1'b0, "bp_drained", 32'(m_valid), 32'd0);
        chk(level == 2'd0, "bp_level_end", 32'(level), 32'd0);

        // drain to empty, then counter wrap at 17 words on the 4-bit instance
        @(posedge clk); #1;
        push(8'h55); push(8'h66); push(8'h77);
        repeat (8) @(negedge clk);
        chk(m_valid == 1'b0, "empty_valid", 32'(m_valid), 32'd0);
        chk(words_out == 16'd17, "empty_words", 32'(words_out), 32'd17);
        chk(words_out4 == 4'd1, "wrap_words", 32'(words_out4), 32'd1);

        // 200 random words under random back-pressure
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) push(8'($urandom));
        budget = 0;
        while (expq.size() != 0 && budget < 3000) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            budget++;
        end
        if (budget >= 3000) chk(1'b0, "rand_timeout", 32'(expq.size()), 32'd0);
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk(words_out == 16'd217, "rand_words", 32'(words_out), 32'd217);
        chk(m_valid == 1'b0, "rand_end_valid", 32'(m_valid), 32'd0);

        // asynchronous reset mid-cycle with two words buffered
        @(posedge clk); #1;
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (6) @(negedge clk);
        chk(level == 2'd2, "pre_rst_level", 32'(level), 32'd2);
        #2 rst = 1'b1;
        expq.delete();
        #1;
        chk(m_valid == 1'b0, "arst_m_valid", 32'(m_valid), 32'd0);
        chk(level == 2'd0, "arst_level", 32'(level), 32'd0);
        chk(words_out == 16'd0, "arst_words", 32'(words_out), 32'd0);
        chk(fifo_r_en == 1'b0, "arst_r_en", 32'(fifo_r_en), 32'd0);
        repeat (2) @(negedge clk);
        chk(m_valid == 1'b0, "arst_hold_valid", 32'(m_valid), 32'd0);
        chk(fifo_r_en == 1'b0, "arst_hold_r_en", 32'(fifo_r_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // recovery after reset
        m_ready = 1'b1;
        push(8'h3C);
        repeat (6) @(negedge clk);
        chk(words_out == 16'd1, "post_rst_words", 32'(words_out), 32'd1);
        chk(expq.size() == 0, "post_rst_delivered", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
